// File: rtl/seq_pkg.sv
// Shared types and opcode constants for the instruction sequencer.
// Contents:
//   seq_state_t    - sequencer state encoding (ST_PAUSE only with SEQ_SINGLE_STEP_EN)
//   OP_STP/OP_LDR  - 5-bit major opcodes (stop, register load)
//   OP_LDA3        - 3-bit major opcode for absolute load
//   INSTR_W/CNT_W  - instruction word and retire-counter widths
// Optional feature macro: SEQ_SINGLE_STEP_EN (adds the PAUSE state).
package seq_pkg;

   localparam int INSTR_W = 16;
   localparam int CNT_W   = 16;

   localparam logic [4:0] OP_STP  = 5'b00000;
   localparam logic [4:0] OP_LDR  = 5'b01110;
   localparam logic [2:0] OP_LDA3 = 3'b110;

   typedef enum logic [2:0] {
      ST_RST   = 3'd0,
      ST_FETCH = 3'd1,
      ST_LOAD  = 3'd2,
      ST_EXEC1 = 3'd3,
      ST_EXEC2 = 3'd4,
      ST_HALT  = 3'd5
`ifdef SEQ_SINGLE_STEP_EN
      ,
      ST_PAUSE = 3'd6
`endif
   } seq_state_t;

endpackage

// File: rtl/op_classifier.sv
// Combinational opcode classifier shared by the sequencer and its checkers.
// Ports:
//   word      in  16  instruction word
//   is_stp    out  1  word is the stop instruction
//   needs_e2  out  1  word executes in two phases (lda or ldr)
module op_classifier
   import seq_pkg::*;
(
   input  logic [INSTR_W-1:0] word,
   output logic               is_stp,
   output logic               needs_e2
);

   // Only the major-opcode field matters here; the operand bits are folded
   // into a deliberately unused net so the port keeps the full word width.
   logic unused_operand;
   assign unused_operand = ^word[10:0];

   assign is_stp   = (word[15:11] == OP_STP);
   assign needs_e2 = (word[15:13] == OP_LDA3) || (word[15:11] == OP_LDR);

endmodule

// File: rtl/instr_sequencer.sv
// Control-phase sequencer and instruction register for the 16-bit core.
// Drives the instruction-memory read (fe), latches the returned word into
// instr, emits the phase strobes e1/e2, handles stop/resume and counts
// retired instructions.
// Ports:
//   clk          in   1  clock, rising edge
//   reset        in   1  synchronous, active-high
//   instr_rdata  in  16  instruction-memory read data, valid the cycle after fe
//   run          in   1  releases HALT
//   step_mode    in   1  park in PAUSE after each instruction (SEQ_SINGLE_STEP_EN)
//   step         in   1  release PAUSE for one instruction (SEQ_SINGLE_STEP_EN)
//   fe/e1/e2     out  1  registered one-hot phase strobes
//   instr        out 16  instruction register
//   halted       out  1  high in HALT
//   instr_count  out 16  retired-instruction counter, wraps
// Optional feature macro: SEQ_SINGLE_STEP_EN.
//
// state    | meaning
// ---------+---------------------------------------------------
// RST      | one cycle after reset, no strobes
// FETCH    | fe high, instruction memory read issued
// LOAD     | read data returns, latched into instr at exit
// EXEC1    | first execute phase; retires one-phase instructions
// EXEC2    | second execute phase (lda/ldr); retires
// HALT     | stp seen, waits for run
// PAUSE    | single-step park, waits for step or step_mode low
module instr_sequencer
   import seq_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic [INSTR_W-1:0] instr_rdata,
   input  logic               run,
`ifdef SEQ_SINGLE_STEP_EN
   input  logic               step_mode,
   input  logic               step,
`endif
   output logic               fe,
   output logic               e1,
   output logic               e2,
   output logic [INSTR_W-1:0] instr,
   output logic               halted,
   output logic [CNT_W-1:0]   instr_count
);

   seq_state_t         state_q, state_d, end_st;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [CNT_W-1:0]   instr_count_q, instr_count_d;
   logic               fe_q, fe_d, e1_q, e1_d, e2_q, e2_d, halted_q, halted_d;

   logic [INSTR_W-1:0] class_word;
   logic               is_stp, needs_e2;

   // One classifier serves both decisions: in LOAD it looks at the incoming
   // word, in EXEC1 at the word already held in the register.
   assign class_word = (state_q == ST_LOAD) ? instr_rdata : instr_q;

   op_classifier u_op_classifier (
      .word     (class_word),
      .is_stp   (is_stp),
      .needs_e2 (needs_e2)
   );

   always_comb begin
      state_d       = state_q;
      instr_d       = instr_q;
      instr_count_d = instr_count_q;
`ifdef SEQ_SINGLE_STEP_EN
      end_st = step_mode ? ST_PAUSE : ST_FETCH;
`else
      end_st = ST_FETCH;
`endif
      case (state_q)
         ST_RST:   state_d = ST_FETCH;
         ST_FETCH: state_d = ST_LOAD;
         ST_LOAD: begin
            instr_d = instr_rdata;
            state_d = is_stp ? ST_HALT : ST_EXEC1;
         end
         ST_EXEC1: begin
            if (needs_e2) begin
               state_d = ST_EXEC2;
            end else begin
               state_d       = end_st;
               instr_count_d = instr_count_q + CNT_W'(1);
            end
         end
         ST_EXEC2: begin
            state_d       = end_st;
            instr_count_d = instr_count_q + CNT_W'(1);
         end
         ST_HALT: begin
            if (run) state_d = ST_FETCH;
         end
`ifdef SEQ_SINGLE_STEP_EN
         ST_PAUSE: begin
            if (step || !step_mode) state_d = ST_FETCH;
         end
`endif
         default: state_d = ST_RST;
      endcase

      // Strobes are decoded from the next state so they come straight off flops.
      fe_d     = (state_d == ST_FETCH);
      e1_d     = (state_d == ST_EXEC1);
      e2_d     = (state_d == ST_EXEC2);
      halted_d = (state_d == ST_HALT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_RST;
         instr_q       <= '0;
         instr_count_q <= '0;
         fe_q          <= 1'b0;
         e1_q          <= 1'b0;
         e2_q          <= 1'b0;
         halted_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         instr_q       <= instr_d;
         instr_count_q <= instr_count_d;
         fe_q          <= fe_d;
         e1_q          <= e1_d;
         e2_q          <= e2_d;
         halted_q      <= halted_d;
      end
   end

   assign fe          = fe_q;
   assign e1          = e1_q;
   assign e2          = e2_q;
   assign halted      = halted_q;
   assign instr       = instr_q;
   assign instr_count = instr_count_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios plus a
// randomized instruction stream checked against a cycle-level model built
// from the phase rules (fetch, load, one or two execute phases, stop/resume).
module tb_instr_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] instr_rdata;
   logic        run;
   logic        fe, e1, e2, halted;
   logic [15:0] instr, instr_count;
`ifdef SEQ_SINGLE_STEP_EN
   logic        step_mode, step;
`endif

   int errors = 0;
   int checks = 0;
   logic [15:0] exp_cnt, exp_instr;

   instr_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .instr_rdata (instr_rdata),
      .run         (run),
`ifdef SEQ_SINGLE_STEP_EN
      .step_mode   (step_mode),
      .step        (step),
`endif
      .fe          (fe),
      .e1          (e1),
      .e2          (e2),
      .instr       (instr),
      .halted      (halted),
      .instr_count (instr_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; run = 1'b0; instr_rdata = 16'hFFFF;
`ifdef SEQ_SINGLE_STEP_EN
      step_mode = 1'b0; step = 1'b0;
`endif
      repeat (3) tick();
      checks++;
      if ({fe, e1, e2, halted} !== 4'b0000 || instr !== 16'h0000 || instr_count !== 16'h0000) begin
         errors++;
         $display("FAIL reset_values: fe/e1/e2/halted=%b%b%b%b instr=%h count=%h, want 0000 0000 0000",
                  fe, e1, e2, halted, instr, instr_count);
      end
      reset = 1'b0;
      tick();
      checks++;
      if (fe !== 1'b1 || e1 !== 1'b0 || halted !== 1'b0) begin
         errors++;
         $display("FAIL first_fetch: fe=%b e1=%b halted=%b, want fe=1 e1=0 halted=0", fe, e1, halted);
      end
      exp_cnt = 16'h0000; exp_instr = 16'h0000;
   endtask

   task automatic test_ldi();
      instr_rdata = 16'h8123;
      tick();
      checks++;
      if ({fe, e1, e2, halted} !== 4'b0000 || instr !== exp_instr) begin
         errors++;
         $display("FAIL ldi_load: strobes=%b%b%b%b instr=%h, want 0000 instr=%h", fe, e1, e2, halted, instr, exp_instr);
      end
      tick();
      checks++;
      if (e1 !== 1'b1 || fe !== 1'b0 || e2 !== 1'b0 || instr !== 16'h8123 || instr_count !== 16'h0000) begin
         errors++;
         $display("FAIL ldi_exec1: fe=%b e1=%b e2=%b instr=%h count=%h, want 0 1 0 8123 0000",
                  fe, e1, e2, instr, instr_count);
      end
      tick();
      checks++;
      if (fe !== 1'b1 || e1 !== 1'b0 || instr_count !== 16'h0001) begin
         errors++;
         $display("FAIL ldi_retire: fe=%b e1=%b count=%h, want fe=1 e1=0 count=0001", fe, e1, instr_count);
      end
      exp_cnt = 16'h0001; exp_instr = 16'h8123;
   endtask

   task automatic test_two_phase();
      logic [15:0] words [2];
      words[0] = 16'hC005; words[1] = 16'h7000;
      for (int k = 0; k < 2; k++) begin
         instr_rdata = words[k];
         tick();
         tick();
         checks++;
         if (e1 !== 1'b1 || e2 !== 1'b0 || instr !== words[k]) begin
            errors++;
            $display("FAIL two_phase_e1[%0d]: e1=%b e2=%b instr=%h, want 1 0 %h", k, e1, e2, instr, words[k]);
         end
         tick();
         checks++;
         if (e2 !== 1'b1 || e1 !== 1'b0 || fe !== 1'b0 || instr !== words[k] || instr_count !== exp_cnt) begin
            errors++;
            $display("FAIL two_phase_e2[%0d]: fe=%b e1=%b e2=%b instr=%h count=%h, want 0 0 1 %h %h",
                     k, fe, e1, e2, instr, instr_count, words[k], exp_cnt);
         end
         tick();
         exp_cnt = exp_cnt + 16'd1;
      end
      exp_instr = 16'h7000;
      checks++;
      if (fe !== 1'b1 || instr_count !== exp_cnt) begin
         errors++;
         $display("FAIL two_phase_count: fe=%b count=%h, want fe=1 count=%h", fe, instr_count, exp_cnt);
      end
   endtask

   task automatic test_stp();
      instr_rdata = 16'h0000;
      tick();
      tick();
      checks++;
      if (halted !== 1'b1 || {fe, e1, e2} !== 3'b000 || instr !== 16'h0000 || instr_count !== exp_cnt) begin
         errors++;
         $display("FAIL stp_halt: halted=%b fe/e1/e2=%b%b%b instr=%h count=%h, want 1 000 0000 %h",
                  halted, fe, e1, e2, instr, instr_count, exp_cnt);
      end
      exp_instr = 16'h0000;
      run = 1'b0;
      for (int k = 0; k < 10; k++) begin
         instr_rdata = 16'($urandom);
         tick();
         checks++;
         if (halted !== 1'b1 || {fe, e1, e2} !== 3'b000 || instr !== 16'h0000 || instr_count !== exp_cnt) begin
            errors++;
            $display("FAIL stp_hold[%0d]: halted=%b fe/e1/e2=%b%b%b instr=%h count=%h", k, halted, fe, e1, e2,
                     instr, instr_count);
         end
      end
      run = 1'b1;
      tick();
      run = 1'b0;
      checks++;
      if (fe !== 1'b1 || halted !== 1'b0) begin
         errors++;
         $display("FAIL stp_resume: fe=%b halted=%b, want fe=1 halted=0", fe, halted);
      end
   endtask

   // Randomized stream; the DUT is at a FETCH sample point on entry and exit.
   task automatic test_random();
      logic [15:0] w;
      bit          stp, two, r;
      for (int n = 0; n < 80; n++) begin
         case ($urandom_range(0, 5))
            0:       w = {5'b00000, 11'($urandom)};
            1:       w = {3'b110, 13'($urandom)};
            2:       w = {5'b01110, 11'($urandom)};
            default: w = 16'($urandom);
         endcase
         stp = (w[15:11] == 5'b00000);
         two = (w[15:13] == 3'b110) || (w[15:11] == 5'b01110);
         checks++;
         if ({fe, e1, e2, halted} !== 4'b1000 || instr !== exp_instr || instr_count !== exp_cnt) begin
            errors++;
            $display("FAIL rnd_fetch[%0d]: strobes=%b%b%b%b instr=%h count=%h, want 1000 %h %h",
                     n, fe, e1, e2, halted, instr, instr_count, exp_instr, exp_cnt);
         end
         instr_rdata = 16'($urandom); run = 1'($urandom);
         tick();
         checks++;
         if ({fe, e1, e2, halted} !== 4'b0000 || instr !== exp_instr) begin
            errors++;
            $display("FAIL rnd_load[%0d]: strobes=%b%b%b%b instr=%h, want 0000 %h", n, fe, e1, e2, halted,
                     instr, exp_instr);
         end
         instr_rdata = w; run = 1'($urandom);
         tick();
         exp_instr = w;
         if (stp) begin
            for (int k = 0; k < 16; k++) begin
               checks++;
               if ({fe, e1, e2, halted} !== 4'b0001 || instr !== w || instr_count !== exp_cnt) begin
                  errors++;
                  $display("FAIL rnd_halt[%0d]: strobes=%b%b%b%b instr=%h count=%h, want 0001 %h %h",
                           n, fe, e1, e2, halted, instr, instr_count, w, exp_cnt);
               end
               instr_rdata = 16'($urandom);
               r = (k == 15) ? 1'b1 : 1'($urandom);
               run = r;
               tick();
               if (r) break;
            end
            run = 1'b0;
         end else begin
            checks++;
            if ({fe, e1, e2, halted} !== 4'b0100 || instr !== w || instr_count !== exp_cnt) begin
               errors++;
               $display("FAIL rnd_e1[%0d]: strobes=%b%b%b%b instr=%h count=%h, want 0100 %h %h",
                        n, fe, e1, e2, halted, instr, instr_count, w, exp_cnt);
            end
            instr_rdata = 16'($urandom); run = 1'($urandom);
            tick();
            if (two) begin
               checks++;
               if ({fe, e1, e2, halted} !== 4'b0010 || instr !== w || instr_count !== exp_cnt) begin
                  errors++;
                  $display("FAIL rnd_e2[%0d]: strobes=%b%b%b%b instr=%h count=%h, want 0010 %h %h",
                           n, fe, e1, e2, halted, instr, instr_count, w, exp_cnt);
               end
               instr_rdata = 16'($urandom); run = 1'($urandom);
               tick();
            end
            exp_cnt = exp_cnt + 16'd1;
         end
      end
      run = 1'b0;
      checks++;
      if (fe !== 1'b1 || instr_count !== exp_cnt) begin
         errors++;
         $display("FAIL rnd_end: fe=%b count=%h, want fe=1 count=%h", fe, instr_count, exp_cnt);
      end
   endtask

   task automatic test_wrap();
      instr_rdata = 16'h8123;
      force dut.instr_count_q = 16'hFFFF;
      tick();
      tick();
      checks++;
      if (e1 !== 1'b1 || instr_count !== 16'hFFFF) begin
         errors++;
         $display("FAIL wrap_pre: e1=%b count=%h, want e1=1 count=ffff", e1, instr_count);
      end
      release dut.instr_count_q;
      tick();
      checks++;
      if (fe !== 1'b1 || instr_count !== 16'h0000) begin
         errors++;
         $display("FAIL wrap: fe=%b count=%h, want fe=1 count=0000", fe, instr_count);
      end
      exp_cnt = 16'h0000; exp_instr = 16'h8123;
   endtask

   task automatic test_reset_mid();
      instr_rdata = 16'hC005;
      tick();
      tick();
      checks++;
      if (e1 !== 1'b1 || instr !== 16'hC005) begin
         errors++;
         $display("FAIL abort_setup: e1=%b instr=%h, want e1=1 instr=c005", e1, instr);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      instr_rdata = 16'h8123;
      checks++;
      if ({fe, e1, e2, halted} !== 4'b0000 || instr !== 16'h0000 || instr_count !== 16'h0000) begin
         errors++;
         $display("FAIL abort: strobes=%b%b%b%b instr=%h count=%h, want 0000 0000 0000",
                  fe, e1, e2, halted, instr, instr_count);
      end
      tick();
      checks++;
      if (fe !== 1'b1 || e2 !== 1'b0) begin
         errors++;
         $display("FAIL abort_refetch: fe=%b e2=%b, want fe=1 e2=0", fe, e2);
      end
      tick();
      tick();
      checks++;
      if (e1 !== 1'b1 || e2 !== 1'b0 || instr !== 16'h8123) begin
         errors++;
         $display("FAIL abort_next: e1=%b e2=%b instr=%h, want 1 0 8123", e1, e2, instr);
      end
      tick();
      checks++;
      if (fe !== 1'b1 || e2 !== 1'b0 || instr_count !== 16'h0001) begin
         errors++;
         $display("FAIL abort_count: fe=%b e2=%b count=%h, want 1 0 0001", fe, e2, instr_count);
      end
      exp_cnt = 16'h0001; exp_instr = 16'h8123;
   endtask

`ifdef SEQ_SINGLE_STEP_EN
   task automatic test_step();
      step_mode = 1'b1;
      instr_rdata = 16'h8123;
      tick();
      tick();
      step = 1'b1;
      tick();
      step = 1'b0;
      exp_cnt = exp_cnt + 16'd1;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if ({fe, e1, e2, halted} !== 4'b0000 || instr_count !== exp_cnt) begin
            errors++;
            $display("FAIL step_park[%0d]: strobes=%b%b%b%b count=%h, want 0000 %h", k, fe, e1, e2, halted,
                     instr_count, exp_cnt);
         end
         tick();
      end
      step = 1'b1;
      tick();
      step = 1'b0;
      checks++;
      if (fe !== 1'b1) begin
         errors++;
         $display("FAIL step_release: fe=%b, want 1", fe);
      end
      tick();
      tick();
      checks++;
      if (e1 !== 1'b1) begin
         errors++;
         $display("FAIL step_exec: e1=%b, want 1", e1);
      end
      tick();
      exp_cnt = exp_cnt + 16'd1;
      checks++;
      if ({fe, e1, e2, halted} !== 4'b0000 || instr_count !== exp_cnt) begin
         errors++;
         $display("FAIL step_repark: strobes=%b%b%b%b count=%h, want 0000 %h", fe, e1, e2, halted,
                  instr_count, exp_cnt);
      end
      step_mode = 1'b0;
      tick();
      checks++;
      if (fe !== 1'b1) begin
         errors++;
         $display("FAIL step_mode_drop: fe=%b, want 1", fe);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_ldi();
      test_two_phase();
      test_stp();
      test_random();
      test_wrap();
      test_reset_mid();
`ifdef SEQ_SINGLE_STEP_EN
      test_step();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
